// File: rtl/fft_serial_result_packer.sv
// Realigns the skewed real/imaginary serial streams from the butterfly processor,
// pairs them, and packs PACK_NUM complex samples per lane into one write-back beat.

module fft_srp_fifo #(
    parameter int unsigned WIDTH = 512,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dat_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;

    // Pointer and occupancy bookkeeping; push and pop may coincide even when full.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_i) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (pop_i) begin
            rptr_d = rptr_q + AW'(1);
        end
        if (push_i && !pop_i) begin
            count_d = count_q + CW'(1);
        end else if (!push_i && pop_i) begin
            count_d = count_q - CW'(1);
        end
        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wptr_q] <= dat_i;
        end
    end

    assign dat_o   = mem_q[rptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;
endmodule

module fft_serial_result_packer #(
    parameter int unsigned data_width      = 16,
    parameter int unsigned be_parallelism  = 32,
    parameter int unsigned OUTPUT_AXI_CHNL = 8,
    parameter int unsigned PACK_NUM        = 4,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned MAX_LENGTH      = 1024
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic [15:0]                                    length,
    input  logic [OUTPUT_AXI_CHNL-1:0]                     up_vld_A,
    input  logic [data_width*be_parallelism-1:0]           up_dat_A,
    output logic                                           up_rdy_A,
    input  logic [OUTPUT_AXI_CHNL-1:0]                     up_vld_B,
    input  logic [data_width*be_parallelism-1:0]           up_dat_B,
    output logic                                           up_rdy_B,
    output logic                                           dn_vld,
    output logic [2*data_width*be_parallelism*PACK_NUM-1:0] dn_dat,
    output logic                                           dn_last,
    input  logic                                           dn_rdy,
    output logic                                           frame_done,
    output logic                                           err_vld_mismatch
);
    localparam int unsigned DW     = data_width;
    localparam int unsigned BE     = be_parallelism;
    localparam int unsigned LANE_W = DW * BE;
    localparam int unsigned OUT_W  = 2 * LANE_W * PACK_NUM;
    localparam int unsigned CNT_W  = $clog2(MAX_LENGTH) + 1;

    logic [LANE_W-1:0] a_dat, b_dat;
    logic              a_full, a_empty, b_full, b_empty;
    logic              push_a_c, push_b_c, pop_c, transfer_c, can_take_c;

    logic [OUT_W-1:0]  acc_q, acc_d;
    logic              complete_q, complete_d;
    logic              acc_last_q, acc_last_d;
    logic [CNT_W-1:0]  sample_cnt_q, sample_cnt_d;
    logic [CNT_W-1:0]  frame_len_q, frame_len_d;
    logic [CNT_W-1:0]  eff_len_c, cur_len_c;
    logic              is_last_c;
    int unsigned       slot_c;

    logic              dn_vld_q, dn_vld_d;
    logic [OUT_W-1:0]  dn_dat_q, dn_dat_d;
    logic              dn_last_q, dn_last_d;
    logic              frame_done_q, frame_done_d;
    logic              err_q, err_d;

    // Accumulator is free if still filling, or if its finished beat leaves this cycle.
    assign transfer_c = complete_q && (!dn_vld_q || dn_rdy);
    assign can_take_c = !complete_q || transfer_c;
    assign pop_c      = !a_empty && !b_empty && can_take_c;

    // A full FIFO still accepts when the same edge pops an entry out of it.
    assign up_rdy_A = !a_full || pop_c;
    assign up_rdy_B = !b_full || pop_c;
    assign push_a_c = (|up_vld_A) && up_rdy_A;
    assign push_b_c = (|up_vld_B) && up_rdy_B;

    fft_srp_fifo #(.WIDTH(LANE_W), .DEPTH(FIFO_DEPTH)) u_fifo_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_a_c),
        .dat_i   (up_dat_A),
        .pop_i   (pop_c),
        .dat_o   (a_dat),
        .full_o  (a_full),
        .empty_o (a_empty)
    );

    fft_srp_fifo #(.WIDTH(LANE_W), .DEPTH(FIFO_DEPTH)) u_fifo_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_b_c),
        .dat_i   (up_dat_B),
        .pop_i   (pop_c),
        .dat_o   (b_dat),
        .full_o  (b_full),
        .empty_o (b_empty)
    );

    assign eff_len_c = ((length == 16'd0) || (32'(length) > MAX_LENGTH))
                     ? CNT_W'(MAX_LENGTH) : CNT_W'(length);

    // Slot placement, frame tracking and beat completion.
    always_comb begin
        acc_d        = acc_q;
        complete_d   = complete_q;
        acc_last_d   = acc_last_q;
        sample_cnt_d = sample_cnt_q;
        frame_len_d  = frame_len_q;
        cur_len_c    = (sample_cnt_q == '0) ? eff_len_c : frame_len_q;
        is_last_c    = (sample_cnt_q == cur_len_c - CNT_W'(1));
        slot_c       = 32'(sample_cnt_q) % PACK_NUM;

        // Clearing on hand-off is what zero-fills the unused slots of a partial beat.
        if (transfer_c) begin
            acc_d      = '0;
            complete_d = 1'b0;
            acc_last_d = 1'b0;
        end
        if (pop_c) begin
            for (int unsigned g = 0; g < BE; g++) begin
                acc_d[(slot_c*BE+g)*2*DW +: DW]      = a_dat[g*DW +: DW];
                acc_d[(slot_c*BE+g)*2*DW + DW +: DW] = b_dat[g*DW +: DW];
            end
            complete_d   = (slot_c == PACK_NUM - 1) || is_last_c;
            acc_last_d   = is_last_c;
            sample_cnt_d = is_last_c ? '0 : sample_cnt_q + CNT_W'(1);
            if (sample_cnt_q == '0) begin
                frame_len_d = eff_len_c;
            end
        end
    end

    // Output register, frame-done pulse and sticky mismatch flag.
    always_comb begin
        dn_vld_d     = dn_vld_q;
        dn_dat_d     = dn_dat_q;
        dn_last_d    = dn_last_q;
        frame_done_d = dn_vld_q && dn_rdy && dn_last_q;
        err_d        = err_q
                     | (push_a_c && (up_vld_A != '1))
                     | (push_b_c && (up_vld_B != '1));
        if (transfer_c) begin
            dn_vld_d  = 1'b1;
            dn_dat_d  = acc_q;
            dn_last_d = acc_last_q;
        end else if (dn_vld_q && dn_rdy) begin
            dn_vld_d  = 1'b0;
            dn_last_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q        <= '0;
            complete_q   <= 1'b0;
            acc_last_q   <= 1'b0;
            sample_cnt_q <= '0;
            frame_len_q  <= '0;
            dn_vld_q     <= 1'b0;
            dn_dat_q     <= '0;
            dn_last_q    <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            complete_q   <= complete_d;
            acc_last_q   <= acc_last_d;
            sample_cnt_q <= sample_cnt_d;
            frame_len_q  <= frame_len_d;
            dn_vld_q     <= dn_vld_d;
            dn_dat_q     <= dn_dat_d;
            dn_last_q    <= dn_last_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
        end
    end

    assign dn_vld           = dn_vld_q;
    assign dn_dat           = dn_dat_q;
    assign dn_last          = dn_last_q;
    assign frame_done       = frame_done_q;
    assign err_vld_mismatch = err_q;
endmodule

// File: tb/tb_fft_serial_result_packer.sv
// Directed-sequence bench for fft_serial_result_packer: random or counting sample
// streams, expected beats rebuilt from the sample lists and frame lengths.

module tb_fft_serial_result_packer;
    localparam int unsigned DW   = 16;
    localparam int unsigned BE   = 32;
    localparam int unsigned NV   = 8;
    localparam int unsigned PK   = 4;
    localparam int unsigned LW   = DW * BE;
    localparam int unsigned OW   = 2 * LW * PK;
    localparam int unsigned MAXL = 1024;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [15:0]   length;
    logic [NV-1:0] up_vld_A, up_vld_B;
    logic [LW-1:0] up_dat_A, up_dat_B;
    logic          up_rdy_A, up_rdy_B;
    logic          dn_vld, dn_last, dn_rdy, frame_done, err_vld_mismatch;
    logic [OW-1:0] dn_dat;

    always #5 clk = ~clk;

    fft_serial_result_packer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .length           (length),
        .up_vld_A         (up_vld_A),
        .up_dat_A         (up_dat_A),
        .up_rdy_A         (up_rdy_A),
        .up_vld_B         (up_vld_B),
        .up_dat_B         (up_dat_B),
        .up_rdy_B         (up_rdy_B),
        .dn_vld           (dn_vld),
        .dn_dat           (dn_dat),
        .dn_last          (dn_last),
        .dn_rdy           (dn_rdy),
        .frame_done       (frame_done),
        .err_vld_mismatch (err_vld_mismatch)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [LW-1:0] a_q[$];
    logic [LW-1:0] b_q[$];
    logic [NV-1:0] a_vld[$];
    logic [OW-1:0] got_dat[$];
    logic          got_last[$];
    int            got_cyc[$];

    int cyc = 0;
    int fd_cnt, stab_err, rdy_a_low, rdy_b_low, a_acc_cnt, a_acc_at_fall, timeouts;
    logic          hold_p = 1'b0;
    logic [OW-1:0] dat_p;
    logic          last_p;

    // Observer: samples settled values once per cycle, between edges.
    always @(negedge clk) begin
        #1;
        cyc++;
        if (rst_n) begin
            if (hold_p && (!dn_vld || dn_dat !== dat_p || dn_last !== last_p)) stab_err++;
            hold_p = dn_vld && !dn_rdy;
            dat_p  = dn_dat;
            last_p = dn_last;
            if (dn_vld && dn_rdy) begin
                got_dat.push_back(dn_dat);
                got_last.push_back(dn_last);
                got_cyc.push_back(cyc);
            end
            if (frame_done) fd_cnt++;
            if (!up_rdy_A) begin
                if (rdy_a_low == 0) a_acc_at_fall = a_acc_cnt;
                rdy_a_low++;
            end
            if (!up_rdy_B) rdy_b_low++;
            if ((|up_vld_A) && up_rdy_A) a_acc_cnt++;
        end else begin
            hold_p = 1'b0;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic clr_mon();
        got_dat.delete();
        got_last.delete();
        got_cyc.delete();
        fd_cnt = 0; stab_err = 0; rdy_a_low = 0; rdy_b_low = 0;
        a_acc_cnt = 0; a_acc_at_fall = -1; timeouts = 0;
    endtask

    task automatic gen(input int n, input bit incr);
        logic [LW-1:0] ra, rb;
        a_q.delete(); b_q.delete(); a_vld.delete();
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < int'(BE); g++) begin
                if (incr) begin
                    ra[g*DW +: DW] = DW'(i*BE + g + 1);
                    rb[g*DW +: DW] = DW'(16'h8000 + i*BE + g + 1);
                end else begin
                    ra[g*DW +: DW] = DW'($urandom);
                    rb[g*DW +: DW] = DW'($urandom);
                end
            end
            a_q.push_back(ra);
            b_q.push_back(rb);
            a_vld.push_back('1);
        end
    endtask

    task automatic drive_a(input int pre, input int stall_at, input int stall_len);
        int t;
        repeat (pre) @(negedge clk);
        for (int i = 0; i < a_q.size(); i++) begin
            if (i == stall_at) begin
                up_vld_A = '0;
                repeat (stall_len) @(negedge clk);
            end
            up_vld_A = a_vld[i];
            up_dat_A = a_q[i];
            t = 0;
            #1;
            while (!up_rdy_A && t < 2000) begin @(negedge clk); #1; t++; end
            if (t >= 2000) timeouts++;
            @(negedge clk);
        end
        up_vld_A = '0;
    endtask

    task automatic drive_b(input int pre);
        int t;
        repeat (pre) @(negedge clk);
        for (int i = 0; i < b_q.size(); i++) begin
            up_vld_B = '1;
            up_dat_B = b_q[i];
            t = 0;
            #1;
            while (!up_rdy_B && t < 2000) begin @(negedge clk); #1; t++; end
            if (t >= 2000) timeouts++;
            @(negedge clk);
        end
        up_vld_B = '0;
    endtask

    task automatic wait_beats(input int n, input int bound);
        int t = 0;
        while (got_dat.size() < n && t < bound) begin @(negedge clk); t++; end
        repeat (4) @(negedge clk);
    endtask

    // Expected stream: nfr frames of len samples, PK samples per beat, tail slots zero.
    task automatic compare_out(input string tag, input int len, input int nfr);
        logic [OW-1:0] exp_d[$];
        logic          exp_l[$];
        logic [OW-1:0] beat;
        logic [LW-1:0] sa, sb;
        int nb, idx, bad_d, bad_l, n;
        for (int f = 0; f < nfr; f++) begin
            nb = (len + PK - 1) / PK;
            for (int k = 0; k < nb; k++) begin
                beat = '0;
                for (int s = 0; s < int'(PK); s++) begin
                    idx = k*PK + s;
                    if (idx < len) begin
                        sa = a_q[f*len + idx];
                        sb = b_q[f*len + idx];
                        for (int g = 0; g < int'(BE); g++) begin
                            beat[(s*BE+g)*2*DW +: DW]      = sa[g*DW +: DW];
                            beat[(s*BE+g)*2*DW + DW +: DW] = sb[g*DW +: DW];
                        end
                    end
                end
                exp_d.push_back(beat);
                exp_l.push_back(k == nb - 1);
            end
        end
        check({tag, " beat_count"}, 64'(got_dat.size()), 64'(exp_d.size()));
        n = (got_dat.size() < exp_d.size()) ? got_dat.size() : exp_d.size();
        bad_d = 0; bad_l = 0;
        for (int i = 0; i < n; i++) begin
            if (got_dat[i] !== exp_d[i]) bad_d++;
            if (got_last[i] !== exp_l[i]) bad_l++;
        end
        check({tag, " bad_data_beats"}, 64'(bad_d), 64'd0);
        check({tag, " bad_last_beats"}, 64'(bad_l), 64'd0);
        check({tag, " frame_done_pulses"}, 64'(fd_cnt), 64'(nfr));
        check({tag, " driver_timeouts"}, 64'(timeouts), 64'd0);
    endtask

    initial begin
        logic [OW-1:0] bt;
        logic [2*DW-1:0] pr, pe;
        logic [LW-1:0] ta, tb2;
        int gaps;

        rst_n = 1'b0; length = '0; dn_rdy = 1'b1;
        up_vld_A = '0; up_vld_B = '0; up_dat_A = '0; up_dat_B = '0;
        clr_mon();
        repeat (3) @(negedge clk);
        #1;
        check("rst dn_vld", 64'(dn_vld), 64'd0);
        check("rst dn_last", 64'(dn_last), 64'd0);
        check("rst dn_dat_nonzero", 64'(|dn_dat), 64'd0);
        check("rst frame_done", 64'(frame_done), 64'd0);
        check("rst err", 64'(err_vld_mismatch), 64'd0);
        check("rst up_rdy_A", 64'(up_rdy_A), 64'd1);
        check("rst up_rdy_B", 64'(up_rdy_B), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Lockstep, length 512, random data
        clr_mon(); gen(512, 1'b0); length = 16'd512;
        fork drive_a(0, -1, 0); drive_b(0); join
        wait_beats(128, 400);
        compare_out("lockstep", 512, 1);
        gaps = 0;
        for (int i = 1; i < got_cyc.size(); i++) if (got_cyc[i] - got_cyc[i-1] != int'(PK)) gaps++;
        check("lockstep beat_spacing_errors", 64'(gaps), 64'd0);
        check("lockstep err", 64'(err_vld_mismatch), 64'd0);

        // Latency: final sample pushed at edge t, dn_vld after t+2
        clr_mon(); gen(4, 1'b0); length = 16'd4;
        for (int i = 0; i < 4; i++) begin
            up_vld_A = '1; up_dat_A = a_q[i];
            up_vld_B = '1; up_dat_B = b_q[i];
            @(negedge clk);
        end
        up_vld_A = '0; up_vld_B = '0;
        #1; check("latency t+0 dn_vld", 64'(dn_vld), 64'd0);
        @(negedge clk); #1; check("latency t+1 dn_vld", 64'(dn_vld), 64'd0);
        @(negedge clk); #1; check("latency t+2 dn_vld", 64'(dn_vld), 64'd1);
        wait_beats(1, 50);
        compare_out("latency", 4, 1);

        // B lags A by 3 cycles
        clr_mon(); gen(8, 1'b0); length = 16'd8;
        fork drive_a(0, -1, 0); drive_b(3); join
        wait_beats(2, 100);
        check("skew3 up_rdy_A_low_cycles", 64'(rdy_a_low), 64'd0);
        compare_out("skew3", 8, 1);
        if (got_dat.size() > 0) begin
            bt = got_dat[0];
            pr = bt[(2*BE+5)*2*DW +: 2*DW];
        end else begin
            pr = 'x;
        end
        ta = a_q[2]; tb2 = b_q[2];
        pe = {tb2[5*DW +: DW], ta[5*DW +: DW]};
        check("skew3 lane5_slot2", 64'(pr), 64'(pe));

        // B stalls 6 cycles: A fills its FIFO
        clr_mon(); gen(8, 1'b0); length = 16'd8;
        fork drive_a(0, -1, 0); drive_b(6); join
        wait_beats(2, 100);
        check("skew6 up_rdy_A_fell", 64'(rdy_a_low > 0), 64'd1);
        check("skew6 A_beats_before_fall", 64'(a_acc_at_fall), 64'd4);
        check("skew6 up_rdy_B_low_cycles", 64'(rdy_b_low), 64'd0);
        compare_out("skew6", 8, 1);

        // Partial last beat
        clr_mon(); gen(6, 1'b0); length = 16'd6;
        fork drive_a(0, -1, 0); drive_b(0); join
        wait_beats(2, 100);
        compare_out("partial", 6, 1);
        if (got_dat.size() > 1) bt = got_dat[1]; else bt = 'x;
        check("partial beat2_upper_slots_nonzero", 64'(|bt[OW-1:OW/2]), 64'd0);

        // Downstream backpressure for 10 cycles mid-frame, counting pattern
        clr_mon(); gen(32, 1'b1); length = 16'd32;
        fork
            drive_a(0, -1, 0);
            drive_b(0);
            begin
                int t = 0;
                while (got_dat.size() < 1 && t < 200) begin @(negedge clk); t++; end
                dn_rdy = 1'b0;
                repeat (10) @(negedge clk);
                dn_rdy = 1'b1;
            end
        join
        wait_beats(8, 200);
        check("bp dn_dat_unstable_cycles", 64'(stab_err), 64'd0);
        check("bp up_rdy_A_fell", 64'(rdy_a_low > 0), 64'd1);
        check("bp up_rdy_B_fell", 64'(rdy_b_low > 0), 64'd1);
        compare_out("bp", 32, 1);

        // Valid-vector mismatch on one A beat; two back-to-back frames
        clr_mon(); gen(16, 1'b0); length = 16'd8;
        a_vld[3] = 8'h0F;
        fork drive_a(0, -1, 0); drive_b(0); join
        wait_beats(4, 100);
        check("mismatch err", 64'(err_vld_mismatch), 64'd1);
        compare_out("mismatch", 8, 2);

        // length 0 runs as a maximum-length frame; err stays sticky
        clr_mon(); gen(int'(MAXL), 1'b0); length = 16'd0;
        fork drive_a(0, -1, 0); drive_b(0); join
        wait_beats(int'(MAXL/PK), 500);
        compare_out("len0", int'(MAXL), 1);
        check("len0 err_sticky", 64'(err_vld_mismatch), 64'd1);

        // Reset in the middle of a 512 frame, then a fresh 16-sample frame
        gen(512, 1'b0); length = 16'd512;
        for (int i = 0; i < 100; i++) begin
            up_vld_A = '1; up_dat_A = a_q[i];
            up_vld_B = '1; up_dat_B = b_q[i];
            @(negedge clk);
        end
        rst_n = 1'b0; up_vld_A = '0; up_vld_B = '0;
        #1;
        check("midrst dn_vld", 64'(dn_vld), 64'd0);
        check("midrst err_cleared", 64'(err_vld_mismatch), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clr_mon(); gen(16, 1'b0); length = 16'd16;
        fork drive_a(0, -1, 0); drive_b(0); join
        wait_beats(4, 100);
        compare_out("postrst", 16, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/fft_serial_result_packer.md
Name: fft_serial_result_packer

Overview:
- Receiving end of the butterfly_processor serial output ports: dn_serial_*_A carries the real parts and dn_serial_*_B carries the imaginary parts, one sample per BE lane per beat.
- Realigns the two streams, which may be skewed, through small per-port FIFOs.
- Pairs each real part with its imaginary part and packs PACK_NUM complex samples per lane into one wide write-back beat.
- Marks the last beat of each length-sample frame for the memory writer.

Parameters:
- data_width, 16, bits per real or imaginary element (fp16)
- be_parallelism, 32, number of BE lanes
- OUTPUT_AXI_CHNL, 8, width of the per-port valid vector
- PACK_NUM, 4, complex samples per lane per output beat (power of 2, ≥1)
- FIFO_DEPTH, 4, entries per port FIFO (power of 2, ≥2)
- MAX_LENGTH, 1024, largest supported frame length

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- length  in  16  samples per frame; sampled at frame start
- up_vld_A  in  OUTPUT_AXI_CHNL  real-stream valid
- up_dat_A  in  data_width*be_parallelism  real parts; lane g at [g*dw +: dw]
- up_rdy_A  out  1  real-stream ready
- up_vld_B  in  OUTPUT_AXI_CHNL  imaginary-stream valid
- up_dat_B  in  data_width*be_parallelism  imaginary parts; same lane layout as A
- up_rdy_B  out  1  imaginary-stream ready
- dn_vld  out  1  output beat valid
- dn_dat  out  2*data_width*be_parallelism*PACK_NUM  packed complex beat
- dn_last  out  1  beat holds sample length-1 of the frame
- dn_rdy  in  1  downstream ready
- frame_done  out  1  single-cycle pulse when the last beat is accepted
- err_vld_mismatch  out  1  sticky valid-vector mismatch flag

Behaviour:
- Reset (async, rst_n=0): FIFOs empty; slot and sample counters 0; all outputs 0 except up_rdy_A/B.
- up_rdy_A/B = 1 in reset and after it, whenever the respective FIFO is not full.
- Port X accepts a beat on a clk edge when |up_vld_X && up_rdy_X. The beat is pushed into FIFO_X with all lanes stored.
- Each port's FIFO is independent; no lockstep between A and B is required.
- Valid mismatch: an accepted beat whose valid vector is neither all-ones nor zero sets err_vld_mismatch. The beat is still accepted. The flag clears only on reset.
- Pop condition: both FIFOs non-empty AND the accumulator can take a sample.
- Accumulator can take a sample when it is not complete, or when it is complete and the output register is empty or being drained this cycle (dn_vld && dn_rdy).
- A pop removes one entry from each FIFO. A push and a pop on the same FIFO in one cycle are both allowed, including when the FIFO is full.
- A FIFO entry is poppable on the edge after its push.
- Accumulator layout: the popped pair goes to slot s = sample_cnt mod PACK_NUM. For lane g, the real part is at bits [(s*be_parallelism+g)*2*dw +: dw] and the imaginary part at +dw above it.
- Frame start: on the pop with sample_cnt==0, the value of length is latched as frame_len. The length input is ignored for the rest of the frame.
- Beat completion: the accumulator is complete when s==PACK_NUM-1 or sample_cnt==frame_len-1.
- Partial last beat: unused slots are zero-filled.
- Transfer to the output register: on the edge after completion, if the output register is free, the beat moves to dn_dat with dn_vld=1. dn_last=1 iff the beat holds sample frame_len-1.
- Throughput: 1 sample pair per cycle sustained.
- Latency: when both halves of the final sample of a beat have been pushed by edge t, dn_vld rises after edge t+2.
- Output hold: while dn_vld && !dn_rdy, dn_dat and dn_last stay stable. The accumulator may fill one further beat and then stall pops. The FIFOs then fill and up_rdy drops.
- frame_done pulses for 1 cycle on the edge after dn_vld && dn_rdy && dn_last.
- End of frame: sample_cnt wraps to 0 and the next frame may start back-to-back in the following cycle.
- Out-of-range length: length==0 or length>MAX_LENGTH is treated as MAX_LENGTH.
- Counter width: $clog2(MAX_LENGTH)+1 bits.
- Reset mid-frame: all partial data is discarded; no dn_last is emitted for the aborted frame.

Test Plan:
- Lockstep, length=512, defaults: A and B both valid 8'hFF for 512 cycles with dn_rdy=1 → 128 beats with dn_vld contiguous; dn_last only on beat 128; one frame_done pulse; err flag stays 0.
- Skew: B lags A by 3 cycles, length=8 → up_rdy_A stays 1. If B stalls 6 cycles, up_rdy_A falls after 4 A beats. Output is 2 beats, with lane 5 slot 2 = {B[2][5], A[2][5]}.
- Partial beat, length=6 → 2 beats; beat 2 slots 2-3 all zero; dn_last=1 on beat 2 only.
- Backpressure: dn_rdy=0 for 10 cycles mid-frame → dn_dat stable; both up_rdy fall after the FIFOs fill. After release, no sample is lost or duplicated (checked against an incrementing pattern 0x0001…).
- Mismatch: one A beat with up_vld_A=8'h0F → err_vld_mismatch=1 and stays set; the beat still appears in the output.
- Reset mid-frame: rst_n low after 100 samples of length=512, then a new length=16 frame → exactly 4 beats; dn_last on beat 4; no stale data.
